// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC datapath arithmetic units.
package cordic_pkg;

    typedef enum logic [1:0] {
        ADD  = 2'd0,
        SUB  = 2'd1,
        ADDS = 2'd2,
        SUBS = 2'd3
    } addsub_op_t;

    // Widest word the saturation constant helpers can describe.
    localparam int MAX_W = 64;

    // Largest positive two's-complement value of width w (0x7F..F), LSB-aligned.
    function automatic logic [MAX_W-1:0] sat_max(input int w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    // Most negative two's-complement value of width w (0x80..0), LSB-aligned.
    function automatic logic [MAX_W-1:0] sat_min(input int w);
        return MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/addsub_segment.sv
// SEG-bit ripple segment of the pipelined adder: sum, carry-out and a
// segment-is-zero bit used to build the overall zero flag.
module addsub_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           cin_i,
    output logic [SEG-1:0] sum_o,
    output logic           cout_o,
    output logic           zero_o
);

    logic [SEG:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        fulladder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (carry[i]),
            .s_o (sum_o[i]),
            .c_o (carry[i+1])
        );
    end

    assign cout_o = carry[SEG];
    assign zero_o = (sum_o == '0);

endmodule

// File: rtl/fulladder.sv
// One-bit full adder cell, the building block of the carry chain.
module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor. The carry chain is split into
// STAGES segments, one per register stage; operands ride along with the
// partial sum so every operation stays coherent. One operation per cycle,
// valid/ready handshake with a global stall, cout/ovf/zero flags.
// Optional signed saturation for ADDS/SUBS: define ADDSUB_SATURATE_EN.
module pipelined_addsub
    import cordic_pkg::*;
#(
    parameter int BITWIDTH = 16,
    parameter int STAGES   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    input  logic [1:0]          op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] result,
    output logic                cout,
    output logic                ovf,
    output logic                zero
);

    localparam int SEG  = BITWIDTH / STAGES;
    localparam int MSB  = BITWIDTH - 1;
    localparam int LAST = STAGES - 1;

    logic                adv;
    logic [BITWIDTH-1:0] b_eff;

    // Per-stage state: operands (b already conditioned), partial sum,
    // carry into the next segment, running zero, valid.
    logic [BITWIDTH-1:0] a_q   [STAGES];
    logic [BITWIDTH-1:0] bx_q  [STAGES];
    logic [BITWIDTH-1:0] sum_q [STAGES];
    logic [BITWIDTH-1:0] a_d   [STAGES];
    logic [BITWIDTH-1:0] bx_d  [STAGES];
    logic [BITWIDTH-1:0] sum_d [STAGES];
    logic [STAGES-1:0]   c_q, c_d;
    logic [STAGES-1:0]   z_q, z_d;
    logic [STAGES-1:0]   vld_q, vld_d;
`ifdef ADDSUB_SATURATE_EN
    logic [STAGES-1:0]   sat_q, sat_d;
`else
    logic                unused_op1;
    assign unused_op1 = op[1];
`endif

    // The whole pipe moves together; a full output that is not taken freezes it.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[LAST];

    // Subtraction is a + ~b + 1, the +1 being the stage-0 carry-in.
    assign b_eff = op[0] ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [BITWIDTH-1:0] SEG_MASK = BITWIDTH'({SEG{1'b1}}) << (k * SEG);

        logic [BITWIDTH-1:0] src_a, src_bx, src_sum;
        logic                src_c, src_z, src_v;
        logic [SEG-1:0]      seg_sum;
        logic                seg_c, seg_z;

        if (k == 0) begin : g_first
            assign src_a   = a;
            assign src_bx  = b_eff;
            assign src_sum = '0;
            assign src_c   = op[0];
            assign src_z   = 1'b1;
            assign src_v   = in_valid;
`ifdef ADDSUB_SATURATE_EN
            assign sat_d[k] = op[1];
`endif
        end else begin : g_next
            assign src_a   = a_q[k-1];
            assign src_bx  = bx_q[k-1];
            assign src_sum = sum_q[k-1];
            assign src_c   = c_q[k-1];
            assign src_z   = z_q[k-1];
            assign src_v   = vld_q[k-1];
`ifdef ADDSUB_SATURATE_EN
            assign sat_d[k] = sat_q[k-1];
`endif
        end

        addsub_segment #(
            .SEG (SEG)
        ) u_seg (
            .a_i    (src_a[k*SEG +: SEG]),
            .b_i    (src_bx[k*SEG +: SEG]),
            .cin_i  (src_c),
            .sum_o  (seg_sum),
            .cout_o (seg_c),
            .zero_o (seg_z)
        );

        assign a_d[k]   = src_a;
        assign bx_d[k]  = src_bx;
        assign sum_d[k] = (src_sum & ~SEG_MASK) | (BITWIDTH'(seg_sum) << (k * SEG));
        assign c_d[k]   = seg_c;
        assign z_d[k]   = src_z & seg_z;
        assign vld_d[k] = src_v;
    end

    // Datapath stage registers: no reset, they only matter when valid is set.
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                bx_q[k]  <= bx_d[k];
                sum_q[k] <= sum_d[k];
            end
            c_q <= c_d;
            z_q <= z_d;
`ifdef ADDSUB_SATURATE_EN
            sat_q <= sat_d;
`endif
        end
    end

    // Valid bits: reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= vld_d;
        end
    end

    // ---- Last stage: flags and optional clamp ----
    logic                raw_ovf;
    logic [BITWIDTH-1:0] res_fin;
    logic                zero_fin;

    assign raw_ovf = (a_q[LAST][MSB] == bx_q[LAST][MSB]) &&
                     (sum_q[LAST][MSB] != a_q[LAST][MSB]);

`ifdef ADDSUB_SATURATE_EN
    localparam logic [BITWIDTH-1:0] SMAX = BITWIDTH'(sat_max(BITWIDTH));
    localparam logic [BITWIDTH-1:0] SMIN = BITWIDTH'(sat_min(BITWIDTH));

    logic clamp;
    assign clamp    = sat_q[LAST] && raw_ovf;
    assign res_fin  = clamp ? (a_q[LAST][MSB] ? SMIN : SMAX) : sum_q[LAST];
    // A clamped value is never zero.
    assign zero_fin = z_q[LAST] && !clamp;
`else
    assign res_fin  = sum_q[LAST];
    assign zero_fin = z_q[LAST];
`endif

    // Outputs read as zero whenever nothing valid is presented.
    assign result = out_valid ? res_fin : '0;
    assign cout   = out_valid && c_q[LAST];
    assign ovf    = out_valid && raw_ovf;
    assign zero   = out_valid && zero_fin;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub (BITWIDTH=16, STAGES=4). Expected results are
// queued when an operation is accepted and compared when it is emitted.
// Build with ADDSUB_SATURATE_EN defined to exercise the clamping variant.
`timescale 1ns/1ps
module tb_pipelined_addsub;
    import cordic_pkg::*;

    localparam int W = 16;
    localparam int S = 4;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready, out_valid, cout, ovf, zero;
    logic [W-1:0] a = '0, b = '0, result;
    addsub_op_t   op = ADD;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(
        .BITWIDTH (W),
        .STAGES   (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic v, input logic z);
        exp_t e;
        e.res = r; e.c = c; e.v = v; e.z = z;
        return e;
    endfunction

    // Reference: integer arithmetic for overflow, widened unsigned for carry.
    function automatic exp_t model(input addsub_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t       e;
        int         sx, sy, t;
        logic [W:0] u;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (o == SUB || o == SUBS) begin
            t = sx - sy;
            u = {1'b0, x} + {1'b0, ~y} + 17'd1;
        end else begin
            t = sx + sy;
            u = {1'b0, x} + {1'b0, y};
        end
        e.c   = u[W];
        e.v   = (t > 32767) || (t < -32768);
        e.res = u[W-1:0];
`ifdef ADDSUB_SATURATE_EN
        if ((o == ADDS || o == SUBS) && e.v) e.res = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
        e.z = (e.res == '0);
        return e;
    endfunction

    // Drive one operation and hold it until accepted (bounded).
    task automatic send(input addsub_op_t o, input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        op = o; a = x; b = y; in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 20);
        chk("accept", acc, 1);
        if (acc) sbq.push_back(e);
        in_valid = 1'b0;
    endtask

    // Called right after the accept edge k of an operation entering an empty pipe.
    task automatic lat_check(input string tag);
        chk({tag, "_lat_k"}, out_valid, 0);
        for (int i = 1; i < S - 1; i++) begin
            @(posedge clk); #1;
            chk({tag, "_lat_mid"}, out_valid, 0);
        end
        @(posedge clk); #1;
        chk({tag, "_lat_out"}, out_valid, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("drain", sbq.size(), 0);
        @(posedge clk); #1;
    endtask

    // Scoreboard consumer: each accepted output beat is compared here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            assert (sbq.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_output: observed result 0x%0h expected no output", result);
            end
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("result", result, mon_e.res);
                chk("cout", cout, mon_e.c);
                chk("ovf", ovf, mon_e.v);
                chk("zero", zero, mon_e.z);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        addsub_op_t   ops [8];
        logic [W-1:0] as  [8];
        logic [W-1:0] bs  [8];
        logic [W-1:0] s_res;
        logic         s_c, s_v, s_z;
        int           seen;

        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_zero", zero, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD wrap to zero, with latency
        send(ADD, 16'h0001, 16'hFFFF, mk(16'h0000, 1'b1, 1'b0, 1'b1));
        lat_check("add_wrap");
        drain();

        // Subtraction borrow / no borrow, back to back
        send(SUB, 16'h0005, 16'h0007, mk(16'hFFFE, 1'b0, 1'b0, 1'b0));
        send(SUB, 16'h0007, 16'h0005, mk(16'h0002, 1'b1, 1'b0, 1'b0));

        // Overflow cases, saturating and wrapping
`ifdef ADDSUB_SATURATE_EN
        send(ADDS, 16'h7FFF, 16'h0001, mk(16'h7FFF, 1'b0, 1'b1, 1'b0));
        send(SUBS, 16'h8000, 16'h0001, mk(16'h8000, 1'b1, 1'b1, 1'b0));
        send(ADDS, 16'h8000, 16'h8000, mk(16'h8000, 1'b1, 1'b1, 1'b0));
`else
        send(ADDS, 16'h7FFF, 16'h0001, mk(16'h8000, 1'b0, 1'b1, 1'b0));
        send(SUBS, 16'h8000, 16'h0001, mk(16'h7FFF, 1'b1, 1'b1, 1'b0));
        send(ADDS, 16'h8000, 16'h8000, mk(16'h0000, 1'b1, 1'b1, 1'b1));
`endif
        send(SUB, 16'h8000, 16'h0001, mk(16'h7FFF, 1'b1, 1'b1, 1'b0));
        send(ADD, 16'h8000, 16'h8000, mk(16'h0000, 1'b1, 1'b1, 1'b1));
        drain();

        // Random stream with a 3-cycle downstream stall after the second result
        for (int i = 0; i < 8; i++) begin
            ops[i] = addsub_op_t'($urandom_range(0, 3));
            as[i]  = W'($urandom);
            bs[i]  = W'($urandom);
        end
        for (int i = 0; i < 6; i++) send(ops[i], as[i], bs[i], model(ops[i], as[i], bs[i]));
        out_ready = 1'b0;
        op = ops[6]; a = as[6]; b = bs[6]; in_valid = 1'b1;
        s_res = result; s_c = cout; s_v = ovf; s_z = zero;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_result", result, s_res);
            chk("stall_cout", cout, s_c);
            chk("stall_ovf", ovf, s_v);
            chk("stall_zero", zero, s_z);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(ops[6], as[6], bs[6], model(ops[6], as[6], bs[6]));
        send(ops[7], as[7], bs[7], model(ops[7], as[7], bs[7]));
        drain();

        // Reset with three operations in flight
        out_ready = 1'b0;
        send(ADD, 16'd10, 16'd20, mk(16'd30, 1'b0, 1'b0, 1'b0));
        send(SUB, 16'd100, 16'd1, mk(16'd99, 1'b1, 1'b0, 1'b0));
        send(ADD, 16'hAAAA, 16'h5555, mk(16'hFFFF, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        chk("inflight_out_valid", out_valid, 1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_result", result, 0);
        chk("midrst_zero", zero, 0);
        sbq.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_ghost_outputs", seen, 0);
        @(posedge clk); #1;
        send(ADD, 16'd2, 16'd3, mk(16'h0005, 1'b0, 1'b0, 1'b0));
        lat_check("post_rst");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
